// File: rtl/trace_reader_if.sv
// Port bundle for trace_reader: request/status signals, the trace buffer read port and
// the 1-bit serial debug stream. "slave" is the reader's view, "master" the surroundings.
interface trace_reader_if #(
  parameter int Fpay  = 32,
  parameter int CNT_W = 10
);
  logic             start;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] avail;
  logic             tb_rd_en;
  logic [Fpay-1:0]  tb_dout;
  logic             tdo;
  logic             tdo_valid;
  logic             tdo_ready;
  logic             busy;
  logic             done;
  logic             underrun;

  modport slave (
    input  start, word_cnt, avail, tb_dout, tdo_ready,
    output tb_rd_en, tdo, tdo_valid, busy, done, underrun
  );

  modport master (
    output start, word_cnt, avail, tb_dout, tdo_ready,
    input  tb_rd_en, tdo, tdo_valid, busy, done, underrun
  );
endinterface

// File: rtl/trace_reader.sv
// Trace buffer unload engine: reads one word at a time from the trace buffer and shifts
// it out LSB-first on a valid/ready serial stream, repeating for the requested word count.
module trace_reader #(
  parameter int Fpay  = 32,
  parameter int CNT_W = 10
) (
  input logic          clk,
  input logic          reset,
  trace_reader_if.slave bus
);

  localparam int               BIT_W    = (Fpay > 1) ? $clog2(Fpay) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(Fpay - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LAT,
    SHIFT,
    FIN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic [Fpay-1:0]  shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic             underrun_q;

  logic             xfer;
  logic             last_bit;

  // A bit leaves only while the word is being presented and the consumer accepts it.
  assign xfer     = (state == SHIFT) && bus.tdo_ready;
  assign last_bit = xfer && (bit_cnt == LAST_BIT);

  // State register; reset abandons any partially shifted word.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and all handshake/status outputs (Moore outputs except the read strobe).
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt     = state;
    bus.tb_rd_en  = 1'b0;
    bus.tdo_valid = 1'b0;
    bus.tdo       = 1'b0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.underrun  = underrun_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.word_cnt == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        // An empty buffer ends the request without ever strobing a read.
        if (bus.avail == '0) begin
          state_nxt = FIN;
        end else begin
          bus.tb_rd_en = 1'b1;
          state_nxt    = LAT;
        end
      end
      LAT: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.tdo_valid = 1'b1;
        bus.tdo       = shreg[0];
        if (last_bit) begin
          // rem still holds the pre-decrement count here, so 1 means this was the last word.
          state_nxt = (rem <= CNT_W'(1)) ? FIN : REQ;
        end
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: remaining-word count, shift register, bit counter and sticky underrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem        <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      underrun_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rem        <= bus.word_cnt;
            underrun_q <= 1'b0;
          end
        end
        REQ: begin
          if (bus.avail == '0) begin
            underrun_q <= 1'b1;
          end
        end
        LAT: begin
          shreg   <= bus.tb_dout;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (xfer) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (last_bit && (rem != '0)) begin
              rem <= rem - CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
